ste_lmc1992: RTL and testbench

//  Downstream consumer of the STE DMA sound engine. Receives the microwire bit stream
//  (mask-qualified clock + data) and decodes LMC1992 commands. Mixes the 8-bit DMA

---
 rtl/ste_lmc1992.sv | 210 +++++++++++++++++++++
 tb/tb_ste_lmc1992.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ste_lmc1992.sv
// ste_lmc1992: LMC1992 microwire command decoder, DMA/YM mixer and stereo attenuator.
// Build option LMC_RAMP_EN: attenuation index walks one step per sample toward its target.
`timescale 1ns/1ps
module ste_lmc1992 #(
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned MW_BITS = 11
) (
    input  logic             clk32,
    input  logic             reset_n,
    input  logic             mw_strobe,
    input  logic             mw_clk,
    input  logic             mw_data,
    input  logic             mw_done,
    input  logic             sample_en,
    input  logic [7:0]       dma_l,
    input  logic [7:0]       dma_r,
    input  logic [7:0]       ym_audio,
    output logic [OUT_W-1:0] audio_out_l,
    output logic [OUT_W-1:0] audio_out_r,
    output logic             out_valid
);

    localparam logic [3:0] CntMax = 4'd15;

    logic [MW_BITS-1:0] sr_q, sr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [5:0]         master_q, master_d;
    logic [4:0]         left_q, left_d, right_q, right_d;
    logic [1:0]         mixer_q, mixer_d;
    logic [3:0]         bass_q, bass_d, treble_q, treble_d;
    logic [5:0]         value;
    logic               cmd_ok;

    // A strobe coinciding with mw_done is shifted first, then the transfer is judged.
    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        master_d = master_q;
        left_d   = left_q;
        right_d  = right_q;
        mixer_d  = mixer_q;
        bass_d   = bass_q;
        treble_d = treble_q;
        if (mw_strobe && mw_clk) begin
            sr_d = {sr_q[MW_BITS-2:0], mw_data};
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        value  = sr_d[5:0];
        cmd_ok = mw_done && (cnt_d == 4'(MW_BITS)) && (sr_d[10:9] == 2'b10);
        if (mw_done) begin
            cnt_d = '0;
        end
        if (cmd_ok) begin
            case (sr_d[8:6])
                3'd0: if (value < 6'd3) mixer_d = value[1:0];
                3'd1: bass_d   = value[3:0];
                3'd2: treble_d = value[3:0];
                3'd3: master_d = (value > 6'd40) ? 6'd40 : value;
                3'd4: right_d  = (value > 6'd20) ? 5'd20 : value[4:0];
                3'd5: left_d   = (value > 6'd20) ? 5'd20 : value[4:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            master_q <= 6'd40;
            left_q   <= 5'd20;
            right_q  <= 5'd20;
            mixer_q  <= 2'd1;
            bass_q   <= 4'd6;
            treble_q <= 4'd6;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            master_q <= master_d;
            left_q   <= left_d;
            right_q  <= right_d;
            mixer_q  <= mixer_d;
            bass_q   <= bass_d;
            treble_q <= treble_d;
        end
    end

    logic [5:0] tgt_l, tgt_r, cur_l, cur_r;

    assign tgt_l = (6'd40 - master_q) + (6'd20 - {1'b0, left_q});
    assign tgt_r = (6'd40 - master_q) + (6'd20 - {1'b0, right_q});

`ifdef LMC_RAMP_EN
    logic [5:0] cur_l_q, cur_r_q;

    function automatic logic [5:0] step_toward(input logic [5:0] cur, input logic [5:0] tgt);
        if (cur < tgt) begin
            return cur + 6'd1;
        end else if (cur > tgt) begin
            return cur - 6'd1;
        end
        return cur;
    endfunction

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            cur_l_q <= '0;
            cur_r_q <= '0;
        end else if (sample_en) begin
            cur_l_q <= step_toward(cur_l_q, tgt_l);
            cur_r_q <= step_toward(cur_r_q, tgt_r);
        end
    end

    assign cur_l = cur_l_q;
    assign cur_r = cur_r_q;
`else
    assign cur_l = tgt_l;
    assign cur_r = tgt_r;
`endif

    // 2 dB per index: three indices per 6 dB octave, so a table of three plus a shift.
    function automatic logic [15:0] att_gain(input logic [5:0] att);
        logic [5:0]  q;
        logic [5:0]  r;
        logic [15:0] t;
        q = att / 6'd3;
        r = att - q * 6'd3;
        case (r)
            6'd0:    t = 16'd32767;
            6'd1:    t = 16'd26028;
            default: t = 16'd20675;
        endcase
        if (q >= 6'd16) begin
            return '0;
        end
        return t >> q[3:0];
    endfunction

    function automatic logic [15:0] sat17(input logic [16:0] s);
        if (s[16] != s[15]) begin
            return s[16] ? 16'h8000 : 16'h7FFF;
        end
        return s[15:0];
    endfunction

    logic [15:0] y_raw, y_mix;

    assign y_raw = {ym_audio ^ 8'h80, 8'h00};

    always_comb begin
        y_mix = '0;
        case (mixer_q)
            2'd0:    y_mix = {{2{y_raw[15]}}, y_raw[15:2]};
            2'd1:    y_mix = y_raw;
            default: y_mix = '0;
        endcase
    end

    logic [15:0] s1_dl_q, s1_dr_q, s1_y_q, s1_gl_q, s1_gr_q;
    logic [15:0] s2_l_q, s2_r_q, s2_gl_q, s2_gr_q;
    logic        s1_v_q, s2_v_q;
    logic signed [32:0] prod_l, prod_r;

    assign prod_l = $signed({{17{s2_l_q[15]}}, s2_l_q}) * $signed({17'd0, s2_gl_q});
    assign prod_r = $signed({{17{s2_r_q[15]}}, s2_r_q}) * $signed({17'd0, s2_gr_q});

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            s1_dl_q     <= '0;
            s1_dr_q     <= '0;
            s1_y_q      <= '0;
            s1_gl_q     <= '0;
            s1_gr_q     <= '0;
            s1_v_q      <= 1'b0;
            s2_l_q      <= '0;
            s2_r_q      <= '0;
            s2_gl_q     <= '0;
            s2_gr_q     <= '0;
            s2_v_q      <= 1'b0;
            audio_out_l <= '0;
            audio_out_r <= '0;
            out_valid   <= 1'b0;
        end else begin
            s1_v_q    <= sample_en;
            s2_v_q    <= s1_v_q;
            out_valid <= s2_v_q;
            if (sample_en) begin
                s1_dl_q <= {dma_l ^ 8'h80, 8'h00};
                s1_dr_q <= {dma_r ^ 8'h80, 8'h00};
                s1_y_q  <= y_mix;
                s1_gl_q <= att_gain(cur_l);
                s1_gr_q <= att_gain(cur_r);
            end
            if (s1_v_q) begin
                s2_l_q  <= sat17({s1_dl_q[15], s1_dl_q} + {s1_y_q[15], s1_y_q});
                s2_r_q  <= sat17({s1_dr_q[15], s1_dr_q} + {s1_y_q[15], s1_y_q});
                s2_gl_q <= s1_gl_q;
                s2_gr_q <= s1_gr_q;
            end
            if (s2_v_q) begin
                audio_out_l <= prod_l[30:15];
                audio_out_r <= prod_r[30:15];
            end
        end
    end

endmodule

// File: tb/tb_ste_lmc1992.sv
// Directed bench for ste_lmc1992: vector table for the mixer datapath plus microwire sequences.
`timescale 1ns/1ps
module tb_ste_lmc1992;

    logic        clk32 = 1'b0;
    logic        reset_n;
    logic        mw_strobe, mw_clk, mw_data, mw_done, sample_en;
    logic [7:0]  dma_l, dma_r, ym_audio;
    logic [15:0] audio_out_l, audio_out_r;
    logic        out_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #16 clk32 = ~clk32;

    ste_lmc1992 dut (
        .clk32       (clk32),
        .reset_n     (reset_n),
        .mw_strobe   (mw_strobe),
        .mw_clk      (mw_clk),
        .mw_data     (mw_data),
        .mw_done     (mw_done),
        .sample_en   (sample_en),
        .dma_l       (dma_l),
        .dma_r       (dma_r),
        .ym_audio    (ym_audio),
        .audio_out_l (audio_out_l),
        .audio_out_r (audio_out_r),
        .out_valid   (out_valid)
    );

    typedef struct {
        logic [7:0]  dl;
        logic [7:0]  dr;
        logic [7:0]  ym;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] cw(input logic [2:0] c, input logic [5:0] v);
        return {2'b10, c, v};
    endfunction

    // Gain of an attenuation index, straight from the 2 dB/step table definition.
    function automatic int gm(input int att);
        int q, r, t;
        q = att / 3;
        r = att % 3;
        t = (r == 0) ? 32767 : (r == 1) ? 26028 : 20675;
        return (q >= 16) ? 0 : (t >> q);
    endfunction

    // Sample in cycle N, outputs checked in cycle N+3.
    task automatic run_sample(input string name, input logic [7:0] dl, input logic [7:0] dr,
                              input logic [7:0] ym, input logic [15:0] el,
                              input logic [15:0] er);
        dma_l = dl; dma_r = dr; ym_audio = ym; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        tick();
        check({name, ".valid"}, 16'(out_valid), 16'd1);
        check({name, ".l"}, audio_out_l, el);
        check({name, ".r"}, audio_out_r, er);
    endtask

    task automatic mw_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mw_strobe = 1'b1; mw_clk = 1'b1; mw_data = bits[i];
            tick();
            mw_strobe = 1'b0; mw_clk = 1'b0;
            tick();
        end
    endtask

    task automatic mw_masked(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mw_strobe = 1'b1; mw_clk = 1'b0; mw_data = ~bits[i];
            tick();
            mw_strobe = 1'b1; mw_clk = 1'b1; mw_data = bits[i];
            tick();
            mw_strobe = 1'b0; mw_clk = 1'b0;
            tick();
        end
    endtask

    task automatic done_pulse();
        mw_done = 1'b1;
        tick();
        mw_done = 1'b0;
        tick();
    endtask

    task automatic settle();
`ifdef LMC_RAMP_EN
        sample_en = 1'b1;
        repeat (64) tick();
        sample_en = 1'b0;
        repeat (4) tick();
`else
        tick();
`endif
    endtask

    task automatic mw_cmd(input logic [10:0] w);
        mw_bits({5'd0, w}, 11);
        done_pulse();
        settle();
    endtask

    task automatic mw_cmd_same_cycle(input logic [10:0] w);
        mw_bits({6'd0, w[10:1]}, 10);
        mw_strobe = 1'b1; mw_clk = 1'b1; mw_data = w[0]; mw_done = 1'b1;
        tick();
        mw_strobe = 1'b0; mw_clk = 1'b0; mw_done = 1'b0;
        tick();
        settle();
    endtask

    initial begin
        int bb [3];
        int g;
        reset_n = 1'b0;
        mw_strobe = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
        sample_en = 1'b0; dma_l = 8'h80; dma_r = 8'h80; ym_audio = 8'h80;

        vecs[0] = '{8'hC0, 8'hC0, 8'h80, 16'h3FFF, 16'h3FFF};
        vecs[1] = '{8'h80, 8'h80, 8'h80, 16'h0000, 16'h0000};
        vecs[2] = '{8'h00, 8'hFF, 8'h80, 16'h8001, 16'h7EFF};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 16'h7FFE, 16'h7FFE};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 16'h8001, 16'h8001};
        vecs[5] = '{8'h80, 8'hC0, 8'hC0, 16'h3FFF, 16'h7FFE};
        vecs[6] = '{8'h40, 8'h40, 8'hC0, 16'h0000, 16'h0000};
        vecs[7] = '{8'h40, 8'h40, 8'h80, 16'hC000, 16'hC000};

        repeat (3) tick();
        check("reset.l", audio_out_l, 16'h0000);
        check("reset.r", audio_out_r, 16'h0000);
        check("reset.valid", 16'(out_valid), 16'd0);
        reset_n = 1'b1;
        tick();

        // Latency: valid exactly at N+3 and for one cycle only.
        dma_l = 8'hC0; dma_r = 8'hC0; ym_audio = 8'h80; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("lat.n1", 16'(out_valid), 16'd0);
        tick();
        check("lat.n2", 16'(out_valid), 16'd0);
        tick();
        check("lat.n3", 16'(out_valid), 16'd1);
        check("lat.l", audio_out_l, 16'h3FFF);
        tick();
        check("lat.n4", 16'(out_valid), 16'd0);

        for (int i = 0; i < 8; i++) begin
            run_sample($sformatf("vec%0d", i), vecs[i].dl, vecs[i].dr, vecs[i].ym,
                       vecs[i].el, vecs[i].er);
        end

        bb[0] = 0; bb[1] = 2; bb[2] = 7;
        for (int k = 0; k < 3; k++) begin
            dma_l = vecs[bb[k]].dl; dma_r = vecs[bb[k]].dr; ym_audio = vecs[bb[k]].ym;
            sample_en = 1'b1;
            tick();
        end
        sample_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b%0d.valid", k), 16'(out_valid), 16'd1);
            check($sformatf("b2b%0d.l", k), audio_out_l, vecs[bb[k]].el);
            check($sformatf("b2b%0d.r", k), audio_out_r, vecs[bb[k]].er);
            tick();
        end

        // master=0: att 40, g=3.
        mw_cmd(cw(3'd3, 6'd0));
        run_sample("m0.ff", 8'hFF, 8'hFF, 8'h80, 16'd2, 16'd2);
        run_sample("m0.c0", 8'hC0, 8'hC0, 8'h80, 16'd1, 16'd1);
        run_sample("m0.00", 8'h00, 8'h00, 8'h80, 16'hFFFD, 16'hFFFD);

        // Malformed transfers leave master at 0.
        mw_bits({6'd0, cw(3'd3, 6'd40) >> 1}, 10);
        done_pulse(); settle();
        run_sample("bad10", 8'hFF, 8'hFF, 8'h80, 16'd2, 16'd2);
        mw_bits({4'd0, 1'b1, cw(3'd3, 6'd40)}, 12);
        done_pulse(); settle();
        run_sample("bad12", 8'hFF, 8'hFF, 8'h80, 16'd2, 16'd2);
        mw_bits({5'd0, 2'b01, 3'd3, 6'd40}, 11);
        done_pulse(); settle();
        run_sample("badaddr", 8'hFF, 8'hFF, 8'h80, 16'd2, 16'd2);
        mw_bits({5'b11111, cw(3'd3, 6'd40)}, 16);
        done_pulse(); settle();
        run_sample("bad16", 8'hFF, 8'hFF, 8'h80, 16'd2, 16'd2);

        // Mask-low slots carry inverted junk and must not be counted.
        mw_masked({5'd0, cw(3'd3, 6'd40)}, 11);
        done_pulse(); settle();
        run_sample("masked", 8'hC0, 8'hC0, 8'h80, 16'h3FFF, 16'h3FFF);

        mw_cmd_same_cycle(cw(3'd3, 6'd0));
        run_sample("samecyc", 8'hC0, 8'hC0, 8'h80, 16'd1, 16'd1);
        mw_cmd(cw(3'd3, 6'd63));
        run_sample("mclamp", 8'hC0, 8'hC0, 8'h80, 16'h3FFF, 16'h3FFF);

        mw_cmd(cw(3'd5, 6'd10));
        run_sample("left10", 8'hC0, 8'hC0, 8'h80, 16'h065A, 16'h3FFF);
        mw_cmd(cw(3'd5, 6'd20));
        mw_cmd(cw(3'd4, 6'd5));
        run_sample("right5", 8'hC0, 8'hC0, 8'h80, 16'h3FFF, 16'h01FF);
        mw_cmd(cw(3'd4, 6'd63));
        run_sample("rclamp", 8'hC0, 8'hC0, 8'h80, 16'h3FFF, 16'h3FFF);

        // Shift count of 16 must mute, not wrap.
        mw_cmd(cw(3'd3, 6'd0));
        mw_cmd(cw(3'd5, 6'd12));
        run_sample("att48", 8'hC0, 8'hC0, 8'h80, 16'h0000, 16'd1);
        mw_cmd(cw(3'd5, 6'd0));
        run_sample("att60", 8'hFF, 8'hFF, 8'h80, 16'h0000, 16'd2);
        mw_cmd(cw(3'd5, 6'd20));
        mw_cmd(cw(3'd3, 6'd40));

        mw_cmd(cw(3'd0, 6'd0));
        run_sample("mix0.ff", 8'h80, 8'h80, 8'hFF, 16'h1FBF, 16'h1FBF);
        run_sample("mix0.00", 8'h80, 8'h80, 8'h00, 16'hE000, 16'hE000);
        mw_cmd(cw(3'd0, 6'd2));
        run_sample("mix2", 8'h80, 8'h80, 8'hFF, 16'h0000, 16'h0000);
        mw_cmd(cw(3'd0, 6'd3));
        run_sample("mix3", 8'h80, 8'h80, 8'hFF, 16'h0000, 16'h0000);
        mw_cmd(cw(3'd6, 6'd0));
        mw_cmd(cw(3'd0, 6'd1));
        run_sample("mix1", 8'hFF, 8'hFF, 8'hFF, 16'h7FFE, 16'h7FFE);

`ifdef LMC_RAMP_EN
        mw_bits({5'd0, cw(3'd3, 6'd34)}, 11);
        done_pulse();
        for (int k = 0; k < 8; k++) begin
            g = gm((k < 6) ? k : 6);
            run_sample($sformatf("ramp%0d", k), 8'hC0, 8'hC0, 8'h80,
                       16'((16384 * g) >> 15), 16'((16384 * g) >> 15));
        end
        mw_cmd(cw(3'd3, 6'd40));
`else
        // Sample in the mw_done cycle keeps the old gain; the next one sees the new gain.
        mw_bits({5'd0, cw(3'd3, 6'd0)}, 11);
        dma_l = 8'hC0; dma_r = 8'hC0; ym_audio = 8'h80;
        mw_done = 1'b1; sample_en = 1'b1;
        tick();
        mw_done = 1'b0;
        tick();
        sample_en = 1'b0;
        tick();
        check("gtime.old", audio_out_l, 16'h3FFF);
        tick();
        check("gtime.new", audio_out_l, 16'd1);
        check("gtime.valid", 16'(out_valid), 16'd1);
        mw_cmd(cw(3'd3, 6'd40));
        mw_cmd(cw(3'd3, 6'd34));
        g = gm(6);
        run_sample("step6", 8'hC0, 8'hC0, 8'h80, 16'((16384 * g) >> 15),
                   16'((16384 * g) >> 15));
        mw_cmd(cw(3'd3, 6'd40));
`endif

        // Reset mid-pipeline clears outputs and registers; a split transfer is lost.
        mw_cmd(cw(3'd3, 6'd0));
        run_sample("prerst", 8'hC0, 8'hC0, 8'h80, 16'd1, 16'd1);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst.l", audio_out_l, 16'h0000);
        check("rst.valid", 16'(out_valid), 16'd0);
        tick();
        reset_n = 1'b1;
        tick();
        mw_bits({11'd0, cw(3'd3, 6'd0) >> 6}, 5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        mw_bits({10'd0, cw(3'd3, 6'd0) & 11'h03F}, 6);
        done_pulse(); settle();
        run_sample("postrst", 8'hC0, 8'hC0, 8'h80, 16'h3FFF, 16'h3FFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
